// File: rtl/decode_pkg.sv
// decode_pkg: instruction type encodings, opcode[6:2] constants and the decoded bundle shared by the decode queue.
package decode_pkg;
    typedef enum logic [2:0] {
        T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5, T_ILLEGAL = 3'd7
    } itype_e;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_LOAD_FP  = 5'b00001;
    localparam logic [4:0] OP_IMM      = 5'b00100;
    localparam logic [4:0] OP_IMM_32   = 5'b00110;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_FP       = 5'b10100;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_STORE_FP = 5'b01001;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_JAL      = 5'b11011;

    // Every RV32 immediate fits in 32 bits; the queue sign-extends it to XLEN on the way out.
    localparam int IMM_W = 32;

    typedef struct packed {
        itype_e           itype;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             rs1_en;
        logic             rs2_en;
        logic             rd_en;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } bundle_t;
endpackage

// File: rtl/instruction_field_decoder.sv
// instruction_field_decoder: combinational RV32 field decode; DECODE_QUEUE_M_EXT_EN makes funct7=0000001 on OP legal.
module instruction_field_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instruction,
    output bundle_t     decoded
);
    logic [4:0] op;
    logic [6:0] f7;
    itype_e     cls;
    logic       f7_ok;
    logic       illegal;

    assign op = instruction[6:2];
    assign f7 = instruction[31:25];
    assign cls = (op == OP_LOAD || op == OP_LOAD_FP || op == OP_IMM || op == OP_IMM_32 || op == OP_JALR) ? T_I :
                 (op == OP_BRANCH)                    ? T_B :
                 (op == OP_OP || op == OP_FP)         ? T_R :
                 (op == OP_STORE || op == OP_STORE_FP) ? T_S :
                 (op == OP_AUIPC || op == OP_LUI)     ? T_U :
                 (op == OP_JAL)                       ? T_J : T_ILLEGAL;
`ifdef DECODE_QUEUE_M_EXT_EN
    assign f7_ok = f7 == 7'b0000000 || f7 == 7'b0100000 || f7 == 7'b0000001;
`else
    assign f7_ok = f7 == 7'b0000000 || f7 == 7'b0100000;
`endif
    assign illegal = instruction[1:0] != 2'b11 || cls == T_ILLEGAL ||
                     (op == OP_OP && !f7_ok) || (op == OP_JALR && instruction[14:12] != 3'b000);

    always_comb begin
        decoded.itype   = illegal ? T_ILLEGAL : cls;
        decoded.opcode  = instruction[6:0];
        decoded.funct3  = instruction[14:12];
        decoded.funct7  = f7;
        decoded.rs1     = instruction[19:15];
        decoded.rs2     = instruction[24:20];
        decoded.rd      = instruction[11:7];
        decoded.rs1_en  = !illegal && cls inside {T_I, T_B, T_S, T_R};
        decoded.rs2_en  = !illegal && cls inside {T_B, T_S, T_R};
        decoded.rd_en   = !illegal && cls inside {T_I, T_U, T_J, T_R} && instruction[11:7] != 5'd0;
        decoded.imm     = illegal    ? '0 :
                          cls == T_I ? {{20{instruction[31]}}, instruction[31:20]} :
                          cls == T_S ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
                          cls == T_B ? {{19{instruction[31]}}, instruction[31], instruction[7],
                                        instruction[30:25], instruction[11:8], 1'b0} :
                          cls == T_U ? {instruction[31:12], 12'b0} :
                          cls == T_J ? {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                        instruction[20], instruction[30:21], 1'b0} : '0;
        decoded.illegal = illegal;
    end
endmodule

// File: rtl/instruction_decode_queue.sv
// instruction_decode_queue: decodes RV32 instructions at push time and buffers the bundles in a DEPTH-entry FIFO.
// Optional M-extension legality via DECODE_QUEUE_M_EXT_EN (handled in instruction_field_decoder).
module instruction_decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instruction,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [2:0]               out_instruction_type,
    output logic [6:0]               out_opcode,
    output logic [2:0]               out_funct3,
    output logic [6:0]               out_funct7,
    output logic [4:0]               out_read_index_1,
    output logic [4:0]               out_read_index_2,
    output logic [4:0]               out_write_index,
    output logic                     out_read_enable_1,
    output logic                     out_read_enable_2,
    output logic                     out_write_enable,
    output logic [XLEN-1:0]          out_immediate,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    bundle_t         dec;
    bundle_t         head;
    bundle_t         mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    instruction_field_decoder u_decoder (
        .instruction (in_instruction),
        .decoded     (dec)
    );

    assign in_ready  = occupancy != FULL;
    assign out_valid = occupancy != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]    <= dec;
            pc_mem[wr_ptr] <= in_pc;
        end
    end

    // Storage is not reset; every visible field is gated by out_valid instead.
    assign head                 = mem[rd_ptr];
    assign out_pc               = out_valid ? pc_mem[rd_ptr] : '0;
    assign out_instruction_type = out_valid ? head.itype : 3'd0;
    assign out_opcode           = out_valid ? head.opcode : '0;
    assign out_funct3           = out_valid ? head.funct3 : '0;
    assign out_funct7           = out_valid ? head.funct7 : '0;
    assign out_read_index_1     = out_valid ? head.rs1 : '0;
    assign out_read_index_2     = out_valid ? head.rs2 : '0;
    assign out_write_index      = out_valid ? head.rd : '0;
    assign out_read_enable_1    = out_valid && head.rs1_en;
    assign out_read_enable_2    = out_valid && head.rs2_en;
    assign out_write_enable     = out_valid && head.rd_en;
    assign out_immediate        = out_valid ? XLEN'($signed(head.imm)) : '0;
    assign out_illegal          = out_valid && head.illegal;
endmodule

// File: tb/tb_instruction_decode_queue.sv
// tb_instruction_decode_queue: directed checks of decode, FIFO ordering, backpressure, flush and async reset.
module tb_instruction_decode_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instruction = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [2:0]  out_instruction_type;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_read_index_1;
    logic [4:0]  out_read_index_2;
    logic [4:0]  out_write_index;
    logic        out_read_enable_1;
    logic        out_read_enable_2;
    logic        out_write_enable;
    logic [31:0] out_immediate;
    logic        out_illegal;
    logic [1:0]  occupancy;
    int          tests = 0;
    int          failed = 0;

    instruction_decode_queue #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instruction_type(out_instruction_type), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_read_index_1(out_read_index_1), .out_read_index_2(out_read_index_2),
        .out_write_index(out_write_index), .out_read_enable_1(out_read_enable_1),
        .out_read_enable_2(out_read_enable_2), .out_write_enable(out_write_enable),
        .out_immediate(out_immediate), .out_illegal(out_illegal), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instruction = instr;
        in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic head(input string tag, input logic [2:0] ty, input logic [31:0] imm,
                        input logic re1, input logic re2, input logic we, input logic ill);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".type"}, out_instruction_type, ty);
        check({tag, ".imm"}, out_immediate, imm);
        check({tag, ".re1"}, out_read_enable_1, re1);
        check({tag, ".re2"}, out_read_enable_2, re2);
        check({tag, ".we"}, out_write_enable, we);
        check({tag, ".illegal"}, out_illegal, ill);
    endtask

    initial begin
        #2;
        check("rst.valid", out_valid, 1'b0);
        check("rst.ready", in_ready, 1'b1);
        check("rst.occ", occupancy, 2'd0);
        check("rst.imm", out_immediate, 32'd0);
        check("rst.pc", out_pc, 32'd0);
        #10 reset = 1'b1;

        push(32'h00500093, 32'h0000_0010);
        head("addi", 3'd1, 32'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        check("addi.rd", out_write_index, 5'd1);
        check("addi.pc", out_pc, 32'h10);
        check("addi.occ", occupancy, 2'd1);
        pop();
        check("pop1.valid", out_valid, 1'b0);

        push(32'hFE112E23, 32'h14);
        head("sw", 3'd2, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sw.rs1", out_read_index_1, 5'd2);
        check("sw.rs2", out_read_index_2, 5'd1);
        pop();

        push(32'h002081B3, 32'h18);
        head("add", 3'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("add.rd", out_write_index, 5'd3);
        check("add.funct7", out_funct7, 7'd0);
        pop();
        push(32'h00208463, 32'h1C);
        head("beq", 3'd3, 32'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        pop();
        push(32'h123452B7, 32'h20);
        head("lui", 3'd4, 32'h1234_5000, 1'b0, 1'b0, 1'b1, 1'b0);
        pop();
        push(32'hFFDFF0EF, 32'h24);
        head("jal", 3'd5, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0);
        pop();
        push(32'h000010E7, 32'h28);
        head("jalr_f3", 3'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop();
        push(32'h00500090, 32'h2C);
        head("low_bits", 3'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop();

        push(32'h02208033, 32'h30);
`ifdef DECODE_QUEUE_M_EXT_EN
        head("mul", 3'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
`else
        head("mul", 3'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        pop();
        check("empty.occ", occupancy, 2'd0);

        push(32'h00500093, 32'h100);
        push(32'h00000013, 32'h104);
        check("full.occ", occupancy, 2'd2);
        check("full.ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_instruction = 32'h0000007F;
        in_pc = 32'h108;
        tick();
        check("held.occ", occupancy, 2'd2);
        check("held.pc", out_pc, 32'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("popfull.occ", occupancy, 2'd1);
        check("popfull.ready", in_ready, 1'b1);
        check("popfull.pc", out_pc, 32'h104);
        tick();
        in_valid = 1'b0;
        check("refill.occ", occupancy, 2'd2);
        head("addi_x0", 3'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pop();
        check("order.pc", out_pc, 32'h108);
        head("illegal7f", 3'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop();
        check("drain.valid", out_valid, 1'b0);

        push(32'h00500093, 32'h200);
        push(32'h00500093, 32'h204);
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        check("flush2.occ", occupancy, 2'd0);
        check("flush2.valid", out_valid, 1'b0);
        in_valid = 1'b0;
        flush = 1'b0;
        push(32'h00500093, 32'h208);
        flush = 1'b1;
        in_valid = 1'b1;
        in_pc = 32'h20C;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush1.occ", occupancy, 2'd0);
        push(32'h00500093, 32'h300);
        check("postflush.pc", out_pc, 32'h300);
        check("postflush.occ", occupancy, 2'd1);

        in_valid = 1'b1;
        in_pc = 32'h400;
        #2 reset = 1'b0;
        #1;
        check("arst.valid", out_valid, 1'b0);
        check("arst.occ", occupancy, 2'd0);
        check("arst.ready", in_ready, 1'b1);
        check("arst.pc", out_pc, 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("arst.idle", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
